pulse_width_meter: RTL and testbench
====================================

PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 Parameter CNT_W, 16, width counter bits (2..32).
REQ-002 Parameter DEPTH, 4, result FIFO entries (power of 2, >=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-005 Rise_Detect  input  1  one-cycle rising-edge pulse from edge_detect.
REQ-006 Fall_Detect  input  1  one-cycle falling-edge pulse from edge_detect.
REQ-007 clr_err  input  1  synchronous clear of sticky error flags.
REQ-008 m_valid  output  1  result record available at FIFO head.
REQ-009 m_ready  input  1  consumer accepts head record.
REQ-010 m_width  output  CNT_W  head record: high-pulse width in clocks.
REQ-011 m_sat  output  1  head record: width saturated.
REQ-012 busy  output  1  high-pulse measurement in progress.
REQ-013 ovf_err  output  1  sticky: record dropped, FIFO full.
REQ-014 seq_err  output  1  sticky: illegal edge sequence seen.

Function
REQ-015 FSM SHALL have two states: IDLE, HIGH; busy SHALL be 1 only in HIGH.
REQ-016 IDLE + Rise_Detect only: go to HIGH, counter <= 1, sat <= 0.
REQ-017 IDLE + Fall_Detect only: ignored, no record, no error (pulse began before reset/start, width unknown).
REQ-018 HIGH, neither pulse: counter += 1, saturating at 2^CNT_W-1; reaching saturation SHALL set record sat bit.
REQ-019 HIGH + Fall_Detect only: push record {sat, counter} into FIFO, go to IDLE; width = cycle of fall pulse minus cycle of rise pulse.
REQ-020 HIGH + Rise_Detect only (missed fall): seq_err <= 1, discard current measurement, stay HIGH, counter <= 1, sat <= 0.
REQ-021 Rise_Detect and Fall_Detect both 1 in any state: seq_err <= 1, both ignored, state and counter hold (no increment).
REQ-022 Pushed record SHALL appear at m_valid/m_width/m_sat the cycle after the fall pulse when FIFO was empty (1-cycle latency).
REQ-023 m_valid SHALL equal FIFO not-empty; m_width/m_sat SHALL reflect head entry.
REQ-024 Pop SHALL occur on a cycle with m_valid && m_ready; m_ready while !m_valid SHALL have no effect.
REQ-025 While m_valid && !m_ready, m_width/m_sat SHALL stay stable.
REQ-026 FIFO SHALL preserve push order; read/write pointers wrap modulo DEPTH.
REQ-027 Push when full with no pop same cycle: record dropped, ovf_err <= 1, FIFO contents unchanged.
REQ-028 Push and pop same cycle when full: both take effect, occupancy unchanged, no ovf_err.
REQ-029 Push and pop same cycle when occupancy is 1: new record becomes head next cycle, m_valid stays 1.
REQ-030 clr_err SHALL clear ovf_err and seq_err next cycle; a new error event in the same cycle SHALL win (flag stays 1).
REQ-031 Only Rise_Detect/Fall_Detect SHALL be used; no raw signal input.

Reset
REQ-032 rst SHALL dominate all other inputs in the cycle sampled.
REQ-033 After reset: state IDLE, counter 0, FIFO empty, m_valid 0, m_width 0, m_sat 0, busy 0, ovf_err 0, seq_err 0.
REQ-034 Reset during HIGH SHALL abandon the measurement; a Fall_Detect following reset SHALL be ignored per REQ-017.
REQ-035 Reset SHALL discard all queued records, including unaccepted head.

Verification
REQ-036 Rise at cycle 10, Fall at cycle 15, m_ready=1 -> m_valid=1 at cycle 16 only, m_width=5, m_sat=0; busy=1 cycles 11-15.
REQ-037 Fall pulse first after reset, then rise@20/fall@21 -> single record m_width=1; no seq_err.
REQ-038 CNT_W=4, rise then fall 20 cycles later -> m_width=15, m_sat=1.
REQ-039 m_ready=0, DEPTH=4, five width-3 pulses -> 4 records held, ovf_err=1; then m_ready=1 -> exactly 4 pops, in order, m_valid=0 after.
REQ-040 Rise, rise 4 cycles later, fall 2 cycles later -> seq_err=1, one record m_width=2; clr_err pulse -> seq_err=0 next cycle.
REQ-041 rst asserted mid-pulse with 2 records queued -> next cycle m_valid=0, busy=0, no record from the interrupted pulse.

Source files
------------

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - measures high-pulse width from rise/fall edge pulses and queues results
// Two-state measurement FSM feeding a small FIFO of {sat, width} records with sticky error flags.

module pulse_width_meter #(
    parameter int CNT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Rise_Detect,
    input  logic             Fall_Detect,
    input  logic             clr_err,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] m_width,
    output logic             m_sat,
    output logic             busy,
    output logic             ovf_err,
    output logic             seq_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, HIGH} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [CNT_W:0]   r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             r_ovf_err;
    logic             r_seq_err;

    logic             w_rise_only;
    logic             w_fall_only;
    logic             w_both;
    logic             w_push;
    logic             w_pop;
    logic             w_wr;
    logic             w_empty;
    logic             w_full;
    logic             w_ovf_evt;
    logic             w_seq_evt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W:0]   w_head;

    assign w_rise_only = Rise_Detect & ~Fall_Detect;
    assign w_fall_only = Fall_Detect & ~Rise_Detect;
    assign w_both      = Rise_Detect & Fall_Detect;
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push    = (r_state == HIGH) && w_fall_only;
    assign w_pop     = ~w_empty & m_ready;
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovf_evt = w_push & w_full & ~w_pop;
    assign w_seq_evt = w_both | ((r_state == HIGH) & w_rise_only);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else if (!w_both) begin
            case (r_state)
                IDLE: begin
                    if (w_rise_only) begin
                        r_state <= HIGH;
                        r_cnt   <= CNT_W'(1);
                        r_sat   <= 1'b0;
                    end
                end
                HIGH: begin
                    if (w_fall_only) begin
                        r_state <= IDLE;
                    end else if (w_rise_only) begin
                        r_cnt <= CNT_W'(1);
                        r_sat <= 1'b0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            r_sat <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= {r_sat, r_cnt};
        end
    end

    // A new error event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_ovf_err <= w_ovf_evt | (r_ovf_err & ~clr_err);
            r_seq_err <= w_seq_evt | (r_seq_err & ~clr_err);
        end
    end

    assign w_head  = r_mem[r_rptr[AW-1:0]];
    assign m_valid = ~w_empty;
    assign m_width = m_valid ? w_head[CNT_W-1:0] : '0;
    assign m_sat   = m_valid & w_head[CNT_W];
    assign busy    = (r_state == HIGH);
    assign ovf_err = r_ovf_err;
    assign seq_err = r_seq_err;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - scoreboard bench for pulse_width_meter (CNT_W=4, DEPTH=4)
module tb_pulse_width_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       Rise_Detect;
    logic       Fall_Detect;
    logic       clr_err;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_width;
    logic       m_sat;
    logic       busy;
    logic       ovf_err;
    logic       seq_err;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_pops   = 0;
    logic [4:0] exp_q [$];
    logic [4:0] exp_rec;
    logic       hold_v = 1'b0;
    logic [3:0] hold_w;
    logic       hold_s;
    int         pops_before;

    pulse_width_meter #(.CNT_W(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .Rise_Detect (Rise_Detect),
        .Fall_Detect (Fall_Detect),
        .clr_err     (clr_err),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_width     (m_width),
        .m_sat       (m_sat),
        .busy        (busy),
        .ovf_err     (ovf_err),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rec_of(input int w);
        if (w >= 15) return 5'b11111;
        return {1'b0, 4'(w)};
    endfunction

    // Rise sampled at edge E0, fall at edge E0+w.
    task automatic pulse(input int w, input bit keep);
        Rise_Detect = 1'b1;
        tick();
        Rise_Detect = 1'b0;
        for (int i = 1; i < w; i++) begin
            chk("busy_hi", busy, 1);
            tick();
        end
        chk("busy_hi", busy, 1);
        Fall_Detect = 1'b1;
        if (keep) exp_q.push_back(rec_of(w));
        tick();
        Fall_Detect = 1'b0;
        chk("busy_lo", busy, 0);
    endtask

    task automatic wait_empty(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (!m_valid) break;
            tick();
        end
        chk("drain_empty", m_valid, 0);
        chk("drain_q", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_width", m_width, hold_w);
                chk("hold_sat", m_sat, hold_s);
            end
            if (m_valid && m_ready) begin
                hold_v = 1'b0;
                n_pops++;
                if (exp_q.size() == 0) begin
                    chk("spurious_rec", 1, 0);
                end else begin
                    exp_rec = exp_q.pop_front();
                    chk("rec_width", m_width, exp_rec[3:0]);
                    chk("rec_sat", m_sat, exp_rec[4]);
                end
            end else if (m_valid) begin
                hold_v = 1'b1;
                hold_w = m_width;
                hold_s = m_sat;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1; Rise_Detect = 1'b0; Fall_Detect = 1'b0; clr_err = 1'b0; m_ready = 1'b1;
        repeat (2) tick();
        chk("rst_valid", m_valid, 0);
        chk("rst_width", m_width, 0);
        chk("rst_sat", m_sat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_seq", seq_err, 0);
        rst = 1'b0;
        tick();

        // Leading fall is ignored, then a width-1 pulse
        Fall_Detect = 1'b1;
        tick();
        Fall_Detect = 1'b0;
        chk("lead_fall_busy", busy, 0);
        chk("lead_fall_valid", m_valid, 0);
        chk("lead_fall_seq", seq_err, 0);
        pulse(1, 1);
        tick();
        chk("w1_seq", seq_err, 0);

        // Width 5: record visible exactly one cycle
        repeat (3) tick();
        pulse(5, 1);
        chk("w5_valid_on", m_valid, 1);
        tick();
        chk("w5_valid_off", m_valid, 0);

        // Saturation boundary
        pulse(20, 1);
        pulse(15, 1);
        pulse(14, 1);
        wait_empty(10);

        // Overflow with consumer stalled
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse(3, 1);
            tick();
        end
        chk("ovf_before", ovf_err, 0);
        pulse(3, 0);
        tick();
        chk("ovf_after", ovf_err, 1);
        chk("ovf_valid", m_valid, 1);
        pops_before = n_pops;
        m_ready = 1'b1;
        wait_empty(10);
        chk("ovf_pops", n_pops - pops_before, 4);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_clr", ovf_err, 0);

        // Ordering under random backpressure
        m_ready = 1'b0;
        pulse(2, 1);
        pulse(7, 1);
        pulse(20, 1);
        pulse(11, 1);
        for (int i = 0; i < 80; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            if (!m_valid && exp_q.size() == 0) break;
        end
        m_ready = 1'b1;
        wait_empty(10);

        // Push and pop in the same cycle while full
        m_ready = 1'b0;
        pulse(3, 1);
        pulse(4, 1);
        pulse(5, 1);
        pulse(6, 1);
        Rise_Detect = 1'b1;
        tick();
        Rise_Detect = 1'b0;
        Fall_Detect = 1'b1;
        m_ready = 1'b1;
        exp_q.push_back(rec_of(1));
        tick();
        Fall_Detect = 1'b0;
        chk("full_pp_ovf", ovf_err, 0);
        chk("full_pp_valid", m_valid, 1);
        wait_empty(10);

        // Push and pop in the same cycle at occupancy 1
        m_ready = 1'b0;
        pulse(2, 1);
        Rise_Detect = 1'b1;
        tick();
        Rise_Detect = 1'b0;
        Fall_Detect = 1'b1;
        m_ready = 1'b1;
        exp_q.push_back(rec_of(1));
        tick();
        Fall_Detect = 1'b0;
        chk("occ1_valid", m_valid, 1);
        tick();
        chk("occ1_empty", m_valid, 0);

        // Missed fall: restart measurement from second rise
        Rise_Detect = 1'b1;
        tick();
        Rise_Detect = 1'b0;
        repeat (3) tick();
        Rise_Detect = 1'b1;
        tick();
        Rise_Detect = 1'b0;
        chk("rr_seq", seq_err, 1);
        chk("rr_busy", busy, 1);
        tick();
        Fall_Detect = 1'b1;
        exp_q.push_back(rec_of(2));
        tick();
        Fall_Detect = 1'b0;
        chk("rr_busy_lo", busy, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("rr_clr", seq_err, 0);

        // Simultaneous edges: error wins over clear, state holds
        clr_err = 1'b1; Rise_Detect = 1'b1; Fall_Detect = 1'b1;
        tick();
        clr_err = 1'b0; Rise_Detect = 1'b0; Fall_Detect = 1'b0;
        chk("both_seq", seq_err, 1);
        chk("both_idle", busy, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("both_clr", seq_err, 0);

        // Simultaneous edges in HIGH freeze the counter for a cycle
        Rise_Detect = 1'b1;
        tick();
        Rise_Detect = 1'b0;
        tick();
        Rise_Detect = 1'b1; Fall_Detect = 1'b1;
        tick();
        Rise_Detect = 1'b0; Fall_Detect = 1'b0;
        chk("both_hi_busy", busy, 1);
        chk("both_hi_seq", seq_err, 1);
        tick();
        Fall_Detect = 1'b1;
        exp_q.push_back(rec_of(3));
        tick();
        Fall_Detect = 1'b0;
        wait_empty(10);

        // Reset mid-pulse with records queued
        m_ready = 1'b0;
        pulse(2, 1);
        pulse(3, 1);
        Rise_Detect = 1'b1;
        tick();
        Rise_Detect = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_width", m_width, 0);
        chk("mid_rst_seq", seq_err, 0);
        Fall_Detect = 1'b1;
        tick();
        Fall_Detect = 1'b0;
        chk("post_rst_fall_valid", m_valid, 0);
        chk("post_rst_fall_seq", seq_err, 0);
        m_ready = 1'b1;
        repeat (2) tick();

        chk("end_q", exp_q.size(), 0);
        chk("end_valid", m_valid, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
